// File: rtl/datamemory_pkg.sv
// Shared types and helpers for the sized data memory: size codes, FSM states,
// response metadata carried alongside the RAM read, and the load/store lane logic.
// No ports; imported by the top level.
package datamemory_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Everything needed to finish a response once the RAM word arrives.
    typedef struct packed {
        logic       vld;
        logic       err;
        logic       we;
        logic [1:0] lane;
        logic [1:0] size;
        logic       uns;
    } rsp_meta_t;

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
        logic bad;
        case (size)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = lane[0];
            SIZE_WORD: bad = (lane != 2'b00);
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Pick the addressed byte/half out of the stored word and extend it to 32 bits.
    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [1:0]  lane,
                                                 input logic [1:0]  size,
                                                 input logic        uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            SIZE_BYTE: r = {{24{~uns & b[7]}}, b};
            SIZE_HALF: r = {{16{~uns & h[15]}}, h};
            default:   r = word;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/datamemory_sized_if.sv
// Request/response bundle between the MEM stage (master) and the data memory (slave).
// Latency: none (wires only).
// Backpressure: req_ready only; responses cannot be stalled.
interface datamemory_sized_if #(
    parameter int ADDR_WIDTH = 12
) ();
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [1:0]            req_size;
    logic                  req_unsigned;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [31:0]           req_wdata;
    logic                  rsp_valid;
    logic [31:0]           rsp_rdata;
    logic                  rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/datamemory_be_ram.sv
// DEPTH x 32 storage with per-byte write enables and a registered read port.
// Latency: read data valid one cycle after the address is presented.
// Backpressure: none; one access per cycle.
// Ports: clk, be (byte lanes to write), addr (word index), wdata, rdata.
module datamemory_be_ram #(
    parameter int WA = 10
) (
    input  logic          clk,
    input  logic [3:0]    be,
    input  logic [WA-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    // Storage is deliberately unreset; the top-level sweep clears it.
    logic [31:0] mem_q [2**WA];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        rdata_q <= mem_q[addr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/datamemory_sized.sv
// MIPS data memory with byte/half/word access, misalignment errors and a post-reset clear sweep.
// Latency: response READ_LATENCY (1 or 2) cycles after accept; one request per cycle.
// Backpressure: req_ready low only during the clear sweep; responses are never stalled.
// Ports: clk, rst_n (async active-low), bus (slave side of datamemory_sized_if), init_done.
module datamemory_sized
    import datamemory_pkg::*;
#(
    parameter int ADDR_WIDTH   = 12,
    parameter int READ_LATENCY = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    datamemory_sized_if.slave  bus,
    output logic               init_done
);
    localparam int WA    = ADDR_WIDTH - 2;
    localparam int DEPTH = 2 ** WA;

    state_t      state_q, state_d;
    logic [WA-1:0] cnt_q, cnt_d;
    rsp_meta_t   meta_q, meta_d;

    logic          accept;
    logic          req_err;
    logic [1:0]    lane;
    logic [3:0]    ram_be;
    logic [WA-1:0] ram_addr;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata;

    logic          rsp1_vld;
    logic          rsp1_err;
    logic [31:0]   rsp1_rdata;

    assign bus.req_ready = (state_q == ST_RUN);
    assign init_done     = (state_q == ST_RUN);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        accept    = 1'b0;
        lane      = bus.req_addr[1:0];
        req_err   = misaligned(bus.req_size, lane);
        ram_be    = 4'h0;
        ram_addr  = bus.req_addr[ADDR_WIDTH-1:2];
        ram_wdata = bus.req_wdata;

        case (state_q)
            ST_INIT: begin
                ram_be    = 4'hF;
                ram_addr  = cnt_q;
                ram_wdata = '0;
                cnt_d     = cnt_q + WA'(1);
                if (cnt_q == WA'(DEPTH - 1)) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end
            default: begin
                accept = bus.req_valid;
                // Sub-word stores replicate the data across lanes so only the enables steer it.
                if (accept && bus.req_we && !req_err) begin
                    case (bus.req_size)
                        SIZE_BYTE: begin
                            ram_be    = 4'b0001 << lane;
                            ram_wdata = {4{bus.req_wdata[7:0]}};
                        end
                        SIZE_HALF: begin
                            ram_be    = lane[1] ? 4'b1100 : 4'b0011;
                            ram_wdata = {2{bus.req_wdata[15:0]}};
                        end
                        default: begin
                            ram_be    = 4'hF;
                            ram_wdata = bus.req_wdata;
                        end
                    endcase
                end
            end
        endcase

        meta_d.vld  = accept;
        meta_d.err  = req_err;
        meta_d.we   = bus.req_we;
        meta_d.lane = lane;
        meta_d.size = bus.req_size;
        meta_d.uns  = bus.req_unsigned;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            meta_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            meta_q  <= meta_d;
        end
    end

    datamemory_be_ram #(.WA(WA)) u_ram (
        .clk   (clk),
        .be    (ram_be),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // First response stage: meta_q lines up with the RAM read data. Gating on
    // vld keeps rdata at 0 out of reset while the RAM still holds garbage.
    always_comb begin
        rsp1_vld   = meta_q.vld;
        rsp1_err   = meta_q.vld & meta_q.err;
        rsp1_rdata = '0;
        if (meta_q.vld && !meta_q.err && !meta_q.we) begin
            rsp1_rdata = load_extract(ram_rdata, meta_q.lane, meta_q.size, meta_q.uns);
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic        rsp_vld_q, rsp_vld_d;
            logic        rsp_err_q, rsp_err_d;
            logic [31:0] rsp_rdata_q, rsp_rdata_d;

            always_comb begin
                rsp_vld_d   = rsp1_vld;
                rsp_err_d   = rsp1_err;
                rsp_rdata_d = rsp1_rdata;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rsp_vld_q   <= 1'b0;
                    rsp_err_q   <= 1'b0;
                    rsp_rdata_q <= '0;
                end else begin
                    rsp_vld_q   <= rsp_vld_d;
                    rsp_err_q   <= rsp_err_d;
                    rsp_rdata_q <= rsp_rdata_d;
                end
            end

            assign bus.rsp_valid = rsp_vld_q;
            assign bus.rsp_err   = rsp_err_q;
            assign bus.rsp_rdata = rsp_rdata_q;
        end else begin : g_lat1
            assign bus.rsp_valid = rsp1_vld;
            assign bus.rsp_err   = rsp1_err;
            assign bus.rsp_rdata = rsp1_rdata;
        end
    endgenerate

endmodule

// File: tb/tb_datamemory_sized.sv
// Bench for datamemory_sized: drives one request stream into an L=1 and an L=2 instance
// and checks every response against hand-computed values and the expected cycle.
module tb_datamemory_sized;
    localparam int AW    = 12;
    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        init_done1, init_done2;

    int nvec = 0;
    int nbad = 0;
    int cyc  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    datamemory_sized_if #(.ADDR_WIDTH(AW)) if1 ();
    datamemory_sized_if #(.ADDR_WIDTH(AW)) if2 ();

    assign if1.req_valid = req_valid;       assign if2.req_valid = req_valid;
    assign if1.req_we = req_we;             assign if2.req_we = req_we;
    assign if1.req_size = req_size;         assign if2.req_size = req_size;
    assign if1.req_unsigned = req_unsigned; assign if2.req_unsigned = req_unsigned;
    assign if1.req_addr = req_addr;         assign if2.req_addr = req_addr;
    assign if1.req_wdata = req_wdata;       assign if2.req_wdata = req_wdata;

    datamemory_sized #(.ADDR_WIDTH(AW), .READ_LATENCY(1)) u_l1 (
        .clk(clk), .rst_n(rst_n), .bus(if1), .init_done(init_done1));
    datamemory_sized #(.ADDR_WIDTH(AW), .READ_LATENCY(2)) u_l2 (
        .clk(clk), .rst_n(rst_n), .bus(if2), .init_done(init_done2));

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];
    vec_t vt[$];

    function automatic vec_t mk(input logic we, input logic [1:0] sz, input logic uns,
                                input logic [11:0] a, input logic [31:0] wd,
                                input logic [31:0] rd, input logic e);
        vec_t v;
        v.we = we; v.size = sz; v.uns = uns; v.addr = a;
        v.wdata = wd; v.rdata = rd; v.err = e;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Response monitors: every pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (if1.rsp_valid === 1'b1) begin
            if (q1.size() == 0) begin
                chk("L1 unexpected rsp_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q1.pop_front();
                chk("L1 rdata", if1.rsp_rdata, e.rdata);
                chk("L1 err", {31'd0, if1.rsp_err}, {31'd0, e.err});
                chk("L1 rsp cycle", cyc, e.cyc);
            end
        end
        if (if2.rsp_valid === 1'b1) begin
            if (q2.size() == 0) begin
                chk("L2 unexpected rsp_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q2.pop_front();
                chk("L2 rdata", if2.rsp_rdata, e.rdata);
                chk("L2 err", {31'd0, if2.rsp_err}, {31'd0, e.err});
                chk("L2 rsp cycle", cyc, e.cyc);
            end
        end
    end

    task automatic issue(input vec_t v);
        exp_t e;
        @(negedge clk);
        req_valid    = 1'b1;
        req_we       = v.we;
        req_size     = v.size;
        req_unsigned = v.uns;
        req_addr     = v.addr;
        req_wdata    = v.wdata;
        #1;
        chk("req_ready", {30'd0, if1.req_ready, if2.req_ready}, 32'd3);
        @(posedge clk);
        #1;
        // cyc now counts the accept edge; L=1 answers in this cycle, L=2 one later.
        e.rdata = v.rdata; e.err = v.err; e.cyc = cyc;
        q1.push_back(e);
        e.cyc = cyc + 1;
        q2.push_back(e);
    endtask

    task automatic idle();
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while ((q1.size() != 0 || q2.size() != 0) && k < 20) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("responses outstanding", q1.size() + q2.size(), 32'd0);
    endtask

    task automatic run_vectors();
        for (int i = 0; i < vt.size(); i++) begin
            issue(vt[i]);
        end
        idle();
        drain();
        vt.delete();
    endtask

    task automatic wait_init();
        int n = 0;
        while (!(init_done1 === 1'b1 && init_done2 === 1'b1) && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("init cycles", n, DEPTH);
        chk("ready after init", {30'd0, if1.req_ready, if2.req_ready}, 32'd3);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " req_ready"}, {30'd0, if1.req_ready, if2.req_ready}, 32'd0);
        chk({tag, " rsp_valid"}, {30'd0, if1.rsp_valid, if2.rsp_valid}, 32'd0);
        chk({tag, " rsp_err"}, {30'd0, if1.rsp_err, if2.rsp_err}, 32'd0);
        chk({tag, " init_done"}, {30'd0, init_done1, init_done2}, 32'd0);
        chk({tag, " rdata L1"}, if1.rsp_rdata, 32'd0);
        chk({tag, " rdata L2"}, if2.rsp_rdata, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state and the clearing sweep.
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        wait_init();

        // Directed table: sizes, extension, lane merge, misalignment, top of memory.
        vt.push_back(mk(0, 2'b10, 0, 12'h3FC, 32'h0,        32'h0,        0));
        vt.push_back(mk(1, 2'b10, 0, 12'h010, 32'h8899AABB, 32'h0,        0));
        vt.push_back(mk(0, 2'b10, 0, 12'h010, 32'h0,        32'h8899AABB, 0));
        vt.push_back(mk(0, 2'b00, 0, 12'h013, 32'h0,        32'hFFFFFF88, 0));
        vt.push_back(mk(0, 2'b00, 1, 12'h013, 32'h0,        32'h00000088, 0));
        vt.push_back(mk(0, 2'b01, 0, 12'h010, 32'h0,        32'hFFFFAABB, 0));
        vt.push_back(mk(0, 2'b01, 1, 12'h012, 32'h0,        32'h00008899, 0));
        vt.push_back(mk(0, 2'b00, 0, 12'h011, 32'h0,        32'hFFFFFFAA, 0));
        vt.push_back(mk(0, 2'b00, 1, 12'h010, 32'h0,        32'h000000BB, 0));
        vt.push_back(mk(0, 2'b01, 0, 12'h012, 32'h0,        32'hFFFF8899, 0));
        vt.push_back(mk(1, 2'b10, 0, 12'h011, 32'h11111111, 32'h0,        1));
        vt.push_back(mk(0, 2'b10, 0, 12'h010, 32'h0,        32'h8899AABB, 0));
        vt.push_back(mk(0, 2'b01, 0, 12'h013, 32'h0,        32'h0,        1));
        vt.push_back(mk(0, 2'b11, 0, 12'h010, 32'h0,        32'h0,        1));
        vt.push_back(mk(1, 2'b11, 0, 12'h010, 32'hFFFFFFFF, 32'h0,        1));
        vt.push_back(mk(0, 2'b10, 0, 12'h012, 32'h0,        32'h0,        1));
        vt.push_back(mk(1, 2'b00, 0, 12'h012, 32'h1234565A, 32'h0,        0));
        vt.push_back(mk(0, 2'b10, 0, 12'h010, 32'h0,        32'h885AAABB, 0));
        vt.push_back(mk(1, 2'b01, 0, 12'h016, 32'hFFFFC0DE, 32'h0,        0));
        vt.push_back(mk(0, 2'b10, 0, 12'h014, 32'h0,        32'hC0DE0000, 0));
        vt.push_back(mk(1, 2'b01, 0, 12'h015, 32'h0000FFFF, 32'h0,        1));
        vt.push_back(mk(0, 2'b10, 0, 12'h014, 32'h0,        32'hC0DE0000, 0));
        vt.push_back(mk(0, 2'b01, 1, 12'h016, 32'h0,        32'h0000C0DE, 0));
        vt.push_back(mk(0, 2'b01, 0, 12'h016, 32'h0,        32'hFFFFC0DE, 0));
        vt.push_back(mk(0, 2'b00, 0, 12'h017, 32'h0,        32'hFFFFFFC0, 0));
        vt.push_back(mk(1, 2'b10, 0, 12'hFFC, 32'hDEADBEEF, 32'h0,        0));
        vt.push_back(mk(0, 2'b10, 0, 12'hFFC, 32'h0,        32'hDEADBEEF, 0));
        vt.push_back(mk(0, 2'b00, 0, 12'hFFC, 32'h0,        32'hFFFFFFEF, 0));
        vt.push_back(mk(0, 2'b00, 1, 12'hFFE, 32'h0,        32'h000000AD, 0));
        vt.push_back(mk(0, 2'b01, 0, 12'hFFE, 32'h0,        32'hFFFFDEAD, 0));
        run_vectors();

        // Back-to-back burst: 16 stores then 16 loads, one per cycle.
        for (int i = 0; i < 16; i++) vt.push_back(mk(1, 2'b10, 0, 12'(4*i), 32'(i), 32'h0, 0));
        for (int i = 0; i < 16; i++) vt.push_back(mk(0, 2'b10, 0, 12'(4*i), 32'h0, 32'(i), 0));
        run_vectors();

        // Reset in the middle of a load burst drops responses and reruns the sweep.
        for (int i = 0; i < 4; i++) issue(mk(0, 2'b10, 0, 12'(4*i), 32'h0, 32'(i), 0));
        #1;
        chk("rsp_valid before mid reset", {31'd0, if1.rsp_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("mid reset");
        q1.delete();
        q2.delete();
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_init();

        vt.push_back(mk(0, 2'b10, 0, 12'h010, 32'h0, 32'h0, 0));
        vt.push_back(mk(0, 2'b10, 0, 12'h004, 32'h0, 32'h0, 0));
        vt.push_back(mk(0, 2'b10, 0, 12'hFFC, 32'h0, 32'h0, 0));
        vt.push_back(mk(0, 2'b01, 0, 12'h014, 32'h0, 32'h0, 0));
        run_vectors();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
